zero_run_detector: RTL and testbench
====================================

Name: zero_run_detector

Overview:
- Parametrised, registered successor to the combinational 32-bit zero checker.
- Samples a WIDTH-bit data word on each valid cycle and produces a registered zero flag.
- Tracks the run length of consecutive zero samples and raises live and sticky flags when the run reaches a programmable threshold.
- Sits beside the ALU/datapath result bus as a status/debug monitor.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- CNT_W, 8, width of run and total counters (>=2).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  sample strobe; in is examined only when high
- in  input  WIDTH  data word under test
- thresh  input  CNT_W  run-length threshold; 0 disables hit detection
- clear  input  1  clears sticky_hit and total_count
- zero  output  1  registered: last valid sample was all-zero
- run_count  output  CNT_W  consecutive valid zero samples, saturating
- total_count  output  CNT_W  valid zero samples since reset/clear, saturating
- run_hit  output  1  live flag: FSM in HIT state
- sticky_hit  output  1  set on any cycle run_hit rises; held until clear/reset

Behaviour:
- Reset (synchronous, reset=1 at clk edge): zero=0, run_count=0, total_count=0, run_hit=0, sticky_hit=0, FSM=IDLE. Reset overrides all other inputs, including in_valid and clear.
- Latency: all outputs are registered. A sample presented at edge N is reflected in the outputs after edge N (one-cycle latency).
- Zero detect: iz = (in == 0) over all WIDTH bits. Evaluated only when in_valid=1.
- in_valid=0: zero, run_count and FSM hold. Only clear can act.
- in_valid=1 with iz=1:
  - zero <= 1
  - run_count <= run_count+1, saturating at 2^CNT_W-1
  - total_count <= total_count+1, saturating at 2^CNT_W-1
- in_valid=1 with iz=0: zero <= 0, run_count <= 0, total_count holds.
- Saturation: counters stick at all-ones and never wrap. Example for CNT_W=8: 255 + zero sample = 255.
- FSM, evaluated only on valid cycles using next_run (the updated run_count) and the current thresh:
  - IDLE: next_run==0 -> IDLE; else if thresh!=0 and next_run>=thresh -> HIT; else -> RUN.
  - RUN: iz=0 -> IDLE; thresh!=0 and next_run>=thresh -> HIT; else RUN.
  - HIT: iz=0 -> IDLE; thresh==0 -> RUN; else HIT (saturated run stays HIT).
- A thresh change with in_valid=0 takes effect at the next valid sample, not immediately.
- run_hit = (state==HIT), registered with the state.
- sticky_hit <= 1 on any edge where the next state is HIT and the current state is not.
- clear=1 with in_valid=1 on the same edge:
  - total_count <= (iz ? 1 : 0), so the current sample is counted after the clear.
  - sticky_hit <= 1 if HIT is entered on this edge, else 0 (set wins over clear).
- clear has no effect on zero, run_count or the FSM.
- thresh=1: a single valid zero sample goes IDLE -> HIT directly.
- Reset mid-run: all state is lost. The next valid zero sample gives run_count=1.

Optional Feature:
- Macro: ZERO_RUN_SIGN_EN.
- When defined: adds output port neg (1 bit), registered as in[WIDTH-1] on valid cycles. neg holds when in_valid=0, resets to 0, and is unaffected by clear.
- When undefined: the neg port does not exist, and the rest of the behaviour is identical.

Test Plan:
- Reset then idle: hold reset 2 cycles, in_valid=0 for 5 cycles -> all outputs 0, FSM IDLE.
- thresh=3, present zero samples 0,0,0 on 3 consecutive valid cycles then 0x00000001 -> run_count 1,2,3,0; run_hit 0,0,1,0; sticky_hit 1 from the 3rd sample until clear; total_count=3; zero 1,1,1,0.
- Gaps: thresh=2, samples zero, in_valid=0 for 4 cycles, zero -> run_count 1,hold 1,2; run_hit rises on the 2nd valid sample only.
- Saturation: CNT_W=4, thresh=0, 20 consecutive zero samples -> run_count and total_count stick at 15; run_hit and sticky_hit stay 0.
- Clear collision: in HIT with sticky_hit=1, assert clear with a nonzero sample -> sticky_hit 0, total_count 0, FSM IDLE; then clear with an entering-HIT sample (thresh=1, zero) -> sticky_hit 1, total_count 1.
- ZERO_RUN_SIGN_EN defined, WIDTH=32: sample 0x80000000 -> zero=0, neg=1; then in_valid=0 -> neg holds 1; then reset -> neg 0.

Source files
------------

// File: rtl/zero_run_detector.sv
// Registered zero detector with saturating run/total counters and a threshold FSM.
// Optional macro ZERO_RUN_SIGN_EN adds a registered sign (neg) output.
module zero_run_detector #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  input  logic [CNT_W-1:0] thresh,
  input  logic             clear,
  output logic             zero,
  output logic [CNT_W-1:0] run_count,
  output logic [CNT_W-1:0] total_count,
  output logic             run_hit,
`ifdef ZERO_RUN_SIGN_EN
  output logic             neg,
`endif
  output logic             sticky_hit
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HIT  = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_t           state_q, state_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic             sticky_q, sticky_d;
  logic             iz;
  logic             thr_hit;
  logic             enter_hit;

  assign iz = (in == '0);
  // Threshold compare uses the post-update run length, so the hit lands on the reaching sample.
  assign thr_hit = (thresh != '0) && (run_d >= thresh);

  always_comb begin
    state_d  = state_q;
    zero_d   = zero_q;
    run_d    = run_q;
    total_d  = clear ? '0 : total_q;
    if (in_valid) begin
      zero_d = iz;
      run_d  = iz ? sat_inc(run_q) : '0;
      if (iz) total_d = sat_inc(total_d);
      unique case (state_q)
        S_IDLE:  state_d = (run_d == '0) ? S_IDLE : (thr_hit ? S_HIT : S_RUN);
        S_RUN:   state_d = !iz ? S_IDLE : (thr_hit ? S_HIT : S_RUN);
        S_HIT:   state_d = !iz ? S_IDLE : ((thresh == '0) ? S_RUN : S_HIT);
        default: state_d = S_IDLE;
      endcase
    end
    enter_hit = (state_d == S_HIT) && (state_q != S_HIT);
    // A hit entry on the same edge as clear keeps the sticky flag set.
    sticky_d  = enter_hit ? 1'b1 : (clear ? 1'b0 : sticky_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      zero_q   <= 1'b0;
      run_q    <= '0;
      total_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      zero_q   <= zero_d;
      run_q    <= run_d;
      total_q  <= total_d;
      sticky_q <= sticky_d;
    end
  end

`ifdef ZERO_RUN_SIGN_EN
  logic neg_q, neg_d;

  always_comb begin
    neg_d = neg_q;
    if (in_valid) neg_d = in[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (reset) neg_q <= 1'b0;
    else       neg_q <= neg_d;
  end

  assign neg = neg_q;
`endif

  assign zero        = zero_q;
  assign run_count   = run_q;
  assign total_count = total_q;
  assign run_hit     = (state_q == S_HIT);
  assign sticky_hit  = sticky_q;

endmodule

// File: tb/tb_zero_run_detector.sv
// Directed bench for zero_run_detector (WIDTH=32, CNT_W=4), with sign checks when ZERO_RUN_SIGN_EN is set.
module tb_zero_run_detector;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in;
  logic [CNT_W-1:0] thresh;
  logic             clear;
  logic             zero;
  logic [CNT_W-1:0] run_count;
  logic [CNT_W-1:0] total_count;
  logic             run_hit;
  logic             sticky_hit;
`ifdef ZERO_RUN_SIGN_EN
  logic             neg;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  zero_run_detector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in          (in),
    .thresh      (thresh),
    .clear       (clear),
    .zero        (zero),
    .run_count   (run_count),
    .total_count (total_count),
    .run_hit     (run_hit),
`ifdef ZERO_RUN_SIGN_EN
    .neg         (neg),
`endif
    .sticky_hit  (sticky_hit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic z, input int run, input int tot,
                         input logic hit, input logic sticky);
    chk({tag, ".zero"},   32'(zero),        32'(z));
    chk({tag, ".run"},    32'(run_count),   32'(run));
    chk({tag, ".total"},  32'(total_count), 32'(tot));
    chk({tag, ".hit"},    32'(run_hit),     32'(hit));
    chk({tag, ".sticky"}, 32'(sticky_hit),  32'(sticky));
  endtask

  // Inputs change 1ns after a rising edge; outputs are sampled at the same point.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic c);
    in_valid = v;
    in       = d;
    clear    = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in = '0; thresh = '0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all("reset", 1'b0, 0, 0, 1'b0, 1'b0);
    repeat (5) step(1'b0, '0, 1'b0);
    chk_all("idle", 1'b0, 0, 0, 1'b0, 1'b0);

    // Run of three zeros reaches thresh=3, then a nonzero sample breaks it.
    thresh = 4'd3;
    step(1'b1, 32'h0, 1'b0);          chk_all("t3_s1", 1'b1, 1, 1, 1'b0, 1'b0);
    step(1'b1, 32'h0, 1'b0);          chk_all("t3_s2", 1'b1, 2, 2, 1'b0, 1'b0);
    step(1'b1, 32'h0, 1'b0);          chk_all("t3_s3", 1'b1, 3, 3, 1'b1, 1'b1);
    step(1'b1, 32'h1, 1'b0);          chk_all("t3_s4", 1'b0, 0, 3, 1'b0, 1'b1);

    // Clear with no valid sample.
    step(1'b0, 32'h0, 1'b1);          chk_all("clr_idle", 1'b0, 0, 0, 1'b0, 1'b0);

    // Gaps between valid zero samples hold the run.
    thresh = 4'd2;
    step(1'b1, 32'h0, 1'b0);          chk_all("gap_s1", 1'b1, 1, 1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'hFFFF_FFFF, 1'b0); chk_all("gap_hold", 1'b1, 1, 1, 1'b0, 1'b0);
    end
    step(1'b1, 32'h0, 1'b0);          chk_all("gap_s2", 1'b1, 2, 2, 1'b1, 1'b1);

    // Clear collisions: leaving HIT clears sticky; entering HIT wins over clear.
    step(1'b1, 32'h0000_0100, 1'b1);  chk_all("clr_nz", 1'b0, 0, 0, 1'b0, 1'b0);
    thresh = 4'd1;
    step(1'b1, 32'h0, 1'b1);          chk_all("clr_hit", 1'b1, 1, 1, 1'b1, 1'b1);
    step(1'b1, 32'h8000_0000, 1'b0);  chk_all("break", 1'b0, 0, 1, 1'b0, 1'b1);

    // Saturation with hit detection disabled.
    thresh = 4'd0;
    step(1'b0, 32'h0, 1'b1);          chk_all("clr2", 1'b0, 0, 0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 32'h0, 1'b0);
      chk_all("sat", 1'b1, (i > 15) ? 15 : i, (i > 15) ? 15 : i, 1'b0, 1'b0);
    end

    // Threshold change during a gap only acts on the next valid sample.
    thresh = 4'd5;
    step(1'b0, 32'h0, 1'b0);          chk_all("thr_gap", 1'b1, 15, 15, 1'b0, 1'b0);
    step(1'b1, 32'h0, 1'b0);          chk_all("thr_apply", 1'b1, 15, 15, 1'b1, 1'b1);
    thresh = 4'd0;
    step(1'b1, 32'h0, 1'b0);          chk_all("hit_to_run", 1'b1, 15, 15, 1'b0, 1'b1);

    // Reset overrides valid and clear; the run restarts from scratch.
    reset = 1'b1;
    step(1'b1, 32'h0, 1'b1);
    reset = 1'b0;
    chk_all("rst_mid", 1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b1, 32'h0, 1'b0);          chk_all("after_rst", 1'b1, 1, 1, 1'b0, 1'b0);

`ifdef ZERO_RUN_SIGN_EN
    step(1'b1, 32'h8000_0000, 1'b0);
    chk("neg_zero", 32'(zero), 32'd0);
    chk("neg_set",  32'(neg),  32'd1);
    step(1'b0, 32'h0, 1'b1);
    chk("neg_hold", 32'(neg),  32'd1);
    step(1'b1, 32'h7FFF_FFFF, 1'b0);
    chk("neg_clr",  32'(neg),  32'd0);
    step(1'b1, 32'hC000_0000, 1'b0);
    chk("neg_set2", 32'(neg),  32'd1);
    reset = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    reset = 1'b0;
    chk("neg_rst",  32'(neg),  32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
